// File: rtl/frogger_pkg.sv
// frogger_pkg: shared direction/state types, screen constants and position clamp
package frogger_pkg;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, HOP, COOLDOWN} state_t;
  localparam logic [4:0] SPRITE_ROW_BASE = 5'd16;
  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;
  function automatic logic [9:0] clamp_pos(input logic [10:0] v, input logic [9:0] hi);
    return v[10] ? 10'd0 : (v[9:0] > hi ? hi : v[9:0]);
  endfunction
endpackage

// File: rtl/frog_motion_fsm.sv
// frog_motion_fsm: hop state machine, frame counter and clamped frog position
module frog_motion_fsm import frogger_pkg::*; #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int START_X = 304,
  parameter int START_Y = 448,
  parameter int HOP_STEP = 8,
  parameter int HOP_FRAMES = 4,
  parameter int COOL_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       move_valid,
  input  logic [1:0] move_dir,
  output logic       move_ready,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y
);
  localparam int SPRITE_PX = 16 << SCALE_SHIFT;
  localparam logic [9:0] X_MAX = 10'(H_PIXELS - SPRITE_PX);
  localparam logic [9:0] Y_MAX = 10'(V_PIXELS - SPRITE_PX);
  state_t state, state_n;
  dir_t dir, dir_n;
  logic [7:0] cnt, cnt_n;
  logic [9:0] x_n, y_n;
  logic [10:0] step, sx, sy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir <= UP;
      cnt <= '0;
      frog_x <= 10'(START_X);
      frog_y <= 10'(START_Y);
    end else begin
      state <= state_n;
      dir <= dir_n;
      cnt <= cnt_n;
      frog_x <= x_n;
      frog_y <= y_n;
    end
  end
  // step is computed 11-bit so underflow past 0 shows up as a set sign bit
  always_comb begin
    step = (dir == DOWN || dir == RIGHT) ? 11'(HOP_STEP) : -11'(HOP_STEP);
    sx = {1'b0, frog_x} + ((dir == LEFT || dir == RIGHT) ? step : 11'd0);
    sy = {1'b0, frog_y} + ((dir == UP || dir == DOWN) ? step : 11'd0);
    state_n = state;
    dir_n = dir;
    cnt_n = cnt;
    x_n = frog_x;
    y_n = frog_y;
    move_ready = state == IDLE;
    case (state)
      IDLE: if (move_valid) begin
        state_n = HOP;
        dir_n = dir_t'(move_dir);
        cnt_n = '0;
      end
      HOP: if (frame_start) begin
        x_n = clamp_pos(sx, X_MAX);
        y_n = clamp_pos(sy, Y_MAX);
        cnt_n = cnt == 8'(HOP_FRAMES - 1) ? 8'd0 : cnt + 8'd1;
        state_n = cnt == 8'(HOP_FRAMES - 1) ? COOLDOWN : HOP;
      end
      COOLDOWN: if (frame_start) begin
        cnt_n = cnt == 8'(COOL_FRAMES - 1) ? 8'd0 : cnt + 8'd1;
        state_n = cnt == 8'(COOL_FRAMES - 1) ? IDLE : COOLDOWN;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/frog_sprite_renderer.sv
// frog_sprite_renderer: frog motion plus 2-stage pixel pipeline driving the sprite ROM
module frog_sprite_renderer import frogger_pkg::*; #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int START_X = 304,
  parameter int START_Y = 448,
  parameter int HOP_STEP = 8,
  parameter int HOP_FRAMES = 4,
  parameter int COOL_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [4:0]  font_addr,
  input  logic [15:0] font_data,
  output logic [9:0]  frog_x,
  output logic [9:0]  frog_y,
  output logic        is_frog
);
  localparam int SPRITE_PX = 16 << SCALE_SHIFT;
  logic [10:0] dx, dy;
  logic inbox, inbox_d;
  logic [3:0] col_d;
  frog_motion_fsm #(
    .H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS), .SCALE_SHIFT(SCALE_SHIFT),
    .START_X(START_X), .START_Y(START_Y), .HOP_STEP(HOP_STEP),
    .HOP_FRAMES(HOP_FRAMES), .COOL_FRAMES(COOL_FRAMES)
  ) u_fsm (
    .clk(Clk),
    .rst(Reset),
    .frame_start(frame_start),
    .move_valid(move_valid),
    .move_dir(move_dir),
    .move_ready(move_ready),
    .frog_x(frog_x),
    .frog_y(frog_y)
  );
  // negative offsets wrap to large unsigned values, so one compare covers both bounds
  assign dx = {1'b0, DrawX} - {1'b0, frog_x};
  assign dy = {1'b0, DrawY} - {1'b0, frog_y};
  assign inbox = dx < 11'(SPRITE_PX) && dy < 11'(SPRITE_PX);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      font_addr <= '0;
      col_d <= '0;
      inbox_d <= 1'b0;
      is_frog <= 1'b0;
    end else begin
      font_addr <= SPRITE_ROW_BASE | {1'b0, dy[SCALE_SHIFT+3:SCALE_SHIFT]};
      col_d <= dx[SCALE_SHIFT+3:SCALE_SHIFT];
      inbox_d <= inbox;
      is_frog <= inbox_d & font_data[4'd15 - col_d];
    end
  end
endmodule

// File: tb/tb_frog_sprite_renderer.sv
// tb_frog_sprite_renderer: random and directed stimulus against a frame-count reference model
module tb_frog_sprite_renderer;
  logic Clk = 0, Reset = 1, frame_start = 0, move_valid = 0;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic [1:0] move_dir = 0;
  logic move_ready, is_frog;
  logic [4:0] font_addr;
  logic [15:0] font_data;
  logic [9:0] frog_x, frog_y;
  logic [15:0] rom [32];
  int checks = 0, errors = 0;
  int m_x = 304, m_y = 448, m_phase = -1, m_dir = 0;
  int e_addr = 0, e_col = 0, e_in = 0, e_frog = 0;
  int pdx, pdy;

  always #5 Clk = ~Clk;
  assign font_data = rom[font_addr];

  frog_sprite_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .font_addr(font_addr), .font_data(font_data), .frog_x(frog_x), .frog_y(frog_y),
    .is_frog(is_frog)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A hop is 6 frame_starts after acceptance: steps on frames 1-4, idle again after frame 6.
  task automatic model_edge();
    if (Reset) begin
      m_x = 304; m_y = 448; m_phase = -1;
      e_addr = 0; e_col = 0; e_in = 0; e_frog = 0;
    end else begin
      pdx = int'(DrawX) - m_x;
      pdy = int'(DrawY) - m_y;
      e_frog = (e_in != 0 && rom[e_addr][15 - e_col]) ? 1 : 0;
      e_addr = 16 + ((pdy & 30) >> 1);
      e_col = (pdx & 30) >> 1;
      e_in = (pdx >= 0 && pdx < 32 && pdy >= 0 && pdy < 32) ? 1 : 0;
      if (m_phase < 0) begin
        if (move_valid) begin m_phase = 0; m_dir = int'(move_dir); end
      end else if (frame_start) begin
        m_phase++;
        if (m_phase <= 4)
          case (m_dir)
            0: m_y = (m_y - 8 < 0) ? 0 : m_y - 8;
            1: m_y = (m_y + 8 > 448) ? 448 : m_y + 8;
            2: m_x = (m_x - 8 < 0) ? 0 : m_x - 8;
            default: m_x = (m_x + 8 > 608) ? 608 : m_x + 8;
          endcase
        if (m_phase == 6) m_phase = -1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit fs, input bit mv, input logic [1:0] d);
    Reset = rst; frame_start = fs; move_valid = mv; move_dir = d;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check("frog_x", frog_x, m_x);
    check("frog_y", frog_y, m_y);
    check("move_ready", move_ready, (m_phase < 0) ? 1 : 0);
    check("font_addr", font_addr, e_addr);
    check("is_frog", is_frog, e_frog);
  endtask

  task automatic rand_draw();
    DrawX = 10'((m_x + $urandom_range(0, 40) + 1020) % 1024);
    DrawY = 10'((m_y + $urandom_range(0, 40) + 1020) % 1024);
  endtask

  task automatic hop(input logic [1:0] d, input bit noisy);
    rand_draw();
    cyc(0, 0, 1, d);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 3; k++) begin
        rand_draw();
        cyc(0, 0, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 3)));
      end
      rand_draw();
      cyc(0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    rom[20][12] = 1'b1;
    rom[20][13] = 1'b0;
    @(negedge Clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("reset_x", frog_x, 304);
    check("reset_y", frog_y, 448);
    check("reset_ready", move_ready, 1);
    check("reset_is_frog", is_frog, 0);
    check("reset_addr", font_addr, 0);
    DrawX = 310; DrawY = 456;
    cyc(0, 0, 0, 0);
    check("addr_row4", font_addr, 20);
    cyc(0, 0, 0, 0);
    check("pix_hit", is_frog, 1);
    DrawX = 308;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("pix_clear_bit", is_frog, 0);
    DrawX = 303;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("pix_outside", is_frog, 0);
    hop(0, 1);
    check("up_hop_y", frog_y, 416);
    check("up_hop_ready", move_ready, 1);
    // reset in the middle of a hop (two steps taken)
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("midhop_rst_y", frog_y, 448);
    check("midhop_rst_ready", move_ready, 1);
    hop(1, 0);
    check("down_clamp_y", frog_y, 448);
    // acceptance with a coincident frame_start takes no step
    cyc(0, 1, 1, 2);
    check("accept_fs_x", frog_x, 304);
    cyc(0, 1, 0, 0);
    check("accept_fs_step", frog_x, 296);
    repeat (5) cyc(0, 1, 0, 0);
    check("accept_fs_done", frog_x, 272);
    for (int h = 0; h < 11; h++) hop(3, 1);
    check("right_clamp_x", frog_x, 608);
    for (int i = 0; i < 1500; i++) begin
      rand_draw();
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
